// File: rtl/mips_exec_units.sv
// Datapath leaf units of the 5-stage MIPS core: a one-cycle registered ALU,
// a 32x32 register file with write-through bypass, and a word-addressed RAM.
// The three units share only clk/rst and are otherwise independent.
module mips_exec_units #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_WORD  = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  // ALU
  input  logic [5:0]           alu_opcode_fwd,
  input  logic [5:0]           alu_funct_fwd,
  input  logic [5:0]           alu_opcode,
  input  logic [5:0]           alu_funct,
  input  logic [31:0]          alu_rrs,
  input  logic [31:0]          alu_rrt,
  input  logic [15:0]          alu_imm,
  input  logic [4:0]           alu_shamt,
  output logic [31:0]          alu_rslt,
  // GPR
  input  logic [4:0]           gpr_rs,
  input  logic [4:0]           gpr_rt,
  output logic [31:0]          gpr_rrs,
  output logic [31:0]          gpr_rrt,
  input  logic [4:0]           gpr_rd,
  input  logic [31:0]          gpr_rrd,
  input  logic                 gpr_we,
  // MEM
  input  logic [31:0]          mem_addr,
  input  logic [MEM_WIDTH-1:0] mem_in,
  input  logic                 mem_we,
  output logic [MEM_WIDTH-1:0] mem_out
);

  localparam int MEM_AW = $clog2(MEM_WORD);

  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ---------------------------------------------------------------- ALU
  // The whole decode fits in the EX cycle, so the early-decode inputs are
  // not needed; they are collected here only to mark them intentionally idle.
  logic        fwd_unused_s;
  assign fwd_unused_s = ^{alu_opcode_fwd, alu_funct_fwd};

  logic [31:0] imm_se_s;
  logic [31:0] imm_ze_s;
  logic [31:0] alu_next_s;
  logic [31:0] alu_rslt_r;

  assign imm_se_s = {{16{alu_imm[15]}}, alu_imm};
  assign imm_ze_s = {16'h0000, alu_imm};

  // Combinational result of the current EX instruction.
  always_comb begin
    alu_next_s = 32'h0000_0000;
    case (alu_opcode)
      OP_R: begin
        case (alu_funct)
          6'd0:  alu_next_s = alu_rrt << alu_shamt;
          6'd2:  alu_next_s = alu_rrt >> alu_shamt;
          6'd3:  alu_next_s = $unsigned($signed(alu_rrt) >>> alu_shamt);
          6'd4:  alu_next_s = alu_rrt << alu_rrs[4:0];
          6'd6:  alu_next_s = alu_rrt >> alu_rrs[4:0];
          6'd7:  alu_next_s = $unsigned($signed(alu_rrt) >>> alu_rrs[4:0]);
          6'd32: alu_next_s = alu_rrs + alu_rrt;
          6'd33: alu_next_s = alu_rrs + alu_rrt;
          6'd34: alu_next_s = alu_rrs - alu_rrt;
          6'd35: alu_next_s = alu_rrs - alu_rrt;
          6'd36: alu_next_s = alu_rrs & alu_rrt;
          6'd37: alu_next_s = alu_rrs | alu_rrt;
          6'd38: alu_next_s = alu_rrs ^ alu_rrt;
          6'd39: alu_next_s = ~(alu_rrs | alu_rrt);
          6'd42: alu_next_s = {31'd0, ($signed(alu_rrs) < $signed(alu_rrt))};
          6'd43: alu_next_s = {31'd0, (alu_rrs < alu_rrt)};
          default: alu_next_s = 32'h0000_0000;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_next_s = alu_rrs + imm_se_s;
      OP_SLTI:  alu_next_s = {31'd0, ($signed(alu_rrs) < $signed(imm_se_s))};
      OP_SLTIU: alu_next_s = {31'd0, (alu_rrs < imm_se_s)};
      OP_ANDI:  alu_next_s = alu_rrs & imm_ze_s;
      OP_ORI:   alu_next_s = alu_rrs | imm_ze_s;
      OP_XORI:  alu_next_s = alu_rrs ^ imm_ze_s;
      OP_LUI:   alu_next_s = {alu_imm, 16'h0000};
      default:  alu_next_s = 32'h0000_0000;
    endcase
  end

  // Result register: one-cycle ALU latency, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_rslt_r <= 32'h0000_0000;
    end else begin
      alu_rslt_r <= alu_next_s;
    end
  end

  assign alu_rslt = alu_rslt_r;

  // ---------------------------------------------------------------- GPR
  logic [31:0] gpr_r [32];
  logic        gpr_wr_s;

  // r0 is never a write target, so it is excluded from the write strobe.
  assign gpr_wr_s = gpr_we && (gpr_rd != 5'd0);

  // Register array: cleared on reset, written on the edge otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_r[i] <= 32'h0000_0000;
      end
    end else if (gpr_wr_s) begin
      gpr_r[gpr_rd] <= gpr_rrd;
    end
  end

  // Read ports: write-through bypass first, then hard-wired zero for r0.
  always_comb begin
    gpr_rrs = 32'h0000_0000;
    gpr_rrt = 32'h0000_0000;
    if (gpr_wr_s && (gpr_rd == gpr_rs)) begin
      gpr_rrs = gpr_rrd;
    end else if (gpr_rs == 5'd0) begin
      gpr_rrs = 32'h0000_0000;
    end else begin
      gpr_rrs = gpr_r[gpr_rs];
    end
    if (gpr_wr_s && (gpr_rd == gpr_rt)) begin
      gpr_rrt = gpr_rrd;
    end else if (gpr_rt == 5'd0) begin
      gpr_rrt = 32'h0000_0000;
    end else begin
      gpr_rrt = gpr_r[gpr_rt];
    end
  end

  // ---------------------------------------------------------------- MEM
  logic [MEM_WIDTH-1:0] mem_r [MEM_WORD];
  logic [MEM_AW-1:0]    mem_idx_s;
  logic                 mem_addr_unused_s;

  // Upper address bits simply alias; only the low index bits select a word.
  assign mem_idx_s         = mem_addr[MEM_AW-1:0];
  assign mem_addr_unused_s = ^mem_addr[31:MEM_AW];

  // Synchronous write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_r[mem_idx_s] <= mem_in;
    end
  end

  assign mem_out = mem_r[mem_idx_s];

endmodule

// File: tb/tb_mips_exec_units.sv
// Self-checking bench for mips_exec_units: directed ALU vector table,
// randomized ALU/GPR/MEM traffic against behavioural models, and
// hand-written sequences for bypass, aliasing and mid-run reset.
module tb_mips_exec_units;

  localparam int MW = 32;
  localparam int MN = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  alu_opcode_fwd, alu_funct_fwd, alu_opcode, alu_funct;
  logic [31:0] alu_rrs, alu_rrt, alu_rslt;
  logic [15:0] alu_imm;
  logic [4:0]  alu_shamt;
  logic [4:0]  gpr_rs, gpr_rt, gpr_rd;
  logic [31:0] gpr_rrs, gpr_rrt, gpr_rrd;
  logic        gpr_we;
  logic [31:0] mem_addr;
  logic [MW-1:0] mem_in, mem_out;
  logic        mem_we;

  int total = 0;
  int bad   = 0;

  mips_exec_units #(.MEM_WIDTH(MW), .MEM_WORD(MN)) dut (
    .clk(clk), .rst(rst),
    .alu_opcode_fwd(alu_opcode_fwd), .alu_funct_fwd(alu_funct_fwd),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_rrs(alu_rrs), .alu_rrt(alu_rrt), .alu_imm(alu_imm),
    .alu_shamt(alu_shamt), .alu_rslt(alu_rslt),
    .gpr_rs(gpr_rs), .gpr_rt(gpr_rt), .gpr_rrs(gpr_rrs), .gpr_rrt(gpr_rrt),
    .gpr_rd(gpr_rd), .gpr_rrd(gpr_rrd), .gpr_we(gpr_we),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vec [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU written straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] imm, input logic [4:0] sh);
    int signed   sa, sb, sse;
    logic [31:0] se, ze;
    longint      amt;
    sa  = a;
    sb  = b;
    se  = {{16{imm[15]}}, imm};
    sse = se;
    ze  = {16'h0000, imm};
    if (op == 6'd0) begin
      amt = (fn == 6'd4 || fn == 6'd6 || fn == 6'd7) ? longint'(a % 32) : longint'(sh);
      case (fn)
        6'd0, 6'd4: return b * (32'd1 << amt);
        6'd2, 6'd6: return b / (32'd1 << amt);
        6'd3, 6'd7: return sb >>> amt;
        6'd32, 6'd33: return a + b;
        6'd34, 6'd35: return a - b;
        6'd36: return a & b;
        6'd37: return a | b;
        6'd38: return a ^ b;
        6'd39: return ~(a | b);
        6'd42: return (sa < sb) ? 32'd1 : 32'd0;
        6'd43: return (a < b) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
    case (op)
      6'd8, 6'd9, 6'd35, 6'd43: return a + se;
      6'd10: return (sa < sse) ? 32'd1 : 32'd0;
      6'd11: return (a < se) ? 32'd1 : 32'd0;
      6'd12: return a & ze;
      6'd13: return a | ze;
      6'd14: return a ^ ze;
      6'd15: return ze * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] gpr_model [32];
  logic [MW-1:0] mem_model [int];

  initial begin
    logic [5:0]  ops [15];
    logic [5:0]  r_op [201];
    logic [5:0]  r_fn [201];
    logic [31:0] e, a, b, ea, eb;
    logic [15:0] im;
    logic [4:0]  sh;
    int          idx;

    vec[0]  = '{6'd0,  6'd32, 32'd5,          32'd7,          16'h0000, 5'd0,  32'd12};
    vec[1]  = '{6'd8,  6'd0,  32'd10,         32'd0,          16'hFFFF, 5'd0,  32'd9};
    vec[2]  = '{6'd13, 6'd0,  32'd10,         32'd0,          16'hFFFF, 5'd0,  32'h0000FFFF};
    vec[3]  = '{6'd15, 6'd0,  32'd0,          32'd0,          16'h1234, 5'd0,  32'h12340000};
    vec[4]  = '{6'd0,  6'd42, 32'hFFFFFFFF,   32'd1,          16'h0000, 5'd0,  32'd1};
    vec[5]  = '{6'd0,  6'd43, 32'hFFFFFFFF,   32'd1,          16'h0000, 5'd0,  32'd0};
    vec[6]  = '{6'd0,  6'd3,  32'd0,          32'h80000000,   16'h0000, 5'd4,  32'hF8000000};
    vec[7]  = '{6'd0,  6'd39, 32'd0,          32'd0,          16'h0000, 5'd0,  32'hFFFFFFFF};
    vec[8]  = '{6'd0,  6'd34, 32'd5,          32'd7,          16'h0000, 5'd0,  32'hFFFFFFFE};
    vec[9]  = '{6'd0,  6'd4,  32'd36,         32'd1,          16'h0000, 5'd0,  32'd16};
    vec[10] = '{6'd11, 6'd0,  32'd5,          32'd0,          16'hFFFF, 5'd0,  32'd1};
    vec[11] = '{6'd4,  6'd0,  32'd3,          32'd3,          16'h0001, 5'd0,  32'd0};
    vec[12] = '{6'd0,  6'd1,  32'd3,          32'd3,          16'h0000, 5'd2,  32'd0};
    vec[13] = '{6'd14, 6'd0,  32'hFFFF0000,   32'd0,          16'h00FF, 5'd0,  32'hFFFF00FF};
    vec[14] = '{6'd0,  6'd2,  32'd0,          32'h80000000,   16'h0000, 5'd31, 32'd1};
    vec[15] = '{6'd12, 6'd0,  32'hFFFFFFFF,   32'd0,          16'h8001, 5'd0,  32'h00008001};
    vec[16] = '{6'd35, 6'd0,  32'd100,        32'd0,          16'hFFFC, 5'd0,  32'd96};

    ops = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11,
            6'd12, 6'd13, 6'd14, 6'd15, 6'd35};

    rst = 1'b1;
    alu_opcode = 6'd0; alu_funct = 6'd32; alu_rrs = 32'd0; alu_rrt = 32'd0;
    alu_imm = 16'd0; alu_shamt = 5'd0;
    alu_opcode_fwd = vec[0].op; alu_funct_fwd = vec[0].fn;
    gpr_rs = 5'd0; gpr_rt = 5'd0; gpr_rd = 5'd0; gpr_rrd = 32'd0; gpr_we = 1'b0;
    mem_addr = 32'd0; mem_in = '0; mem_we = 1'b0;
    for (int i = 0; i < 32; i++) gpr_model[i] = 32'd0;
    repeat (2) step();
    check("reset_alu", alu_rslt, 32'd0);
    gpr_rs = 5'd5; gpr_rt = 5'd31;
    #1;
    check("reset_gpr_rs", gpr_rrs, 32'd0);
    check("reset_gpr_rt", gpr_rrt, 32'd0);
    rst = 1'b0;
    step();
    check("post_reset_alu", alu_rslt, 32'd0);

    // Directed ALU vectors; _fwd always shows the following vector.
    for (int i = 0; i < 17; i++) begin
      alu_opcode = vec[i].op; alu_funct = vec[i].fn;
      alu_rrs = vec[i].rs; alu_rrt = vec[i].rt;
      alu_imm = vec[i].imm; alu_shamt = vec[i].sh;
      alu_opcode_fwd = (i < 16) ? vec[i+1].op : 6'd0;
      alu_funct_fwd  = (i < 16) ? vec[i+1].fn : 6'd0;
      step();
      check($sformatf("alu_vec%0d", i), alu_rslt, vec[i].exp);
    end

    // Randomized ALU traffic.
    for (int i = 0; i < 201; i++) begin
      r_op[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                            : ops[$urandom_range(0, 14)];
      r_fn[i] = 6'($urandom_range(0, 63));
    end
    for (int i = 0; i < 200; i++) begin
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom();
      im = 16'($urandom());
      sh = 5'($urandom());
      alu_opcode = r_op[i]; alu_funct = r_fn[i];
      alu_rrs = a; alu_rrt = b; alu_imm = im; alu_shamt = sh;
      alu_opcode_fwd = r_op[i+1]; alu_funct_fwd = r_fn[i+1];
      e = ref_alu(r_op[i], r_fn[i], a, b, im, sh);
      step();
      check($sformatf("alu_rand op=%0d fn=%0d", r_op[i], r_fn[i]), alu_rslt, e);
    end

    // GPR directed: write r3, write r0, bypass on r7.
    gpr_we = 1'b1; gpr_rd = 5'd3; gpr_rrd = 32'h0000DEAD;
    step();
    gpr_we = 1'b0; gpr_rs = 5'd3;
    #1;
    check("gpr_r3", gpr_rrs, 32'h0000DEAD);
    gpr_we = 1'b1; gpr_rd = 5'd0; gpr_rrd = 32'd5; gpr_rs = 5'd0; gpr_rt = 5'd0;
    #1;
    check("gpr_r0_bypass", gpr_rrs, 32'd0);
    step();
    gpr_we = 1'b0;
    #1;
    check("gpr_r0_after", gpr_rrs, 32'd0);
    gpr_we = 1'b1; gpr_rd = 5'd7; gpr_rrd = 32'd42; gpr_rs = 5'd7; gpr_rt = 5'd7;
    #1;
    check("gpr_bypass_rs", gpr_rrs, 32'd42);
    check("gpr_bypass_rt", gpr_rrt, 32'd42);
    step();
    gpr_we = 1'b0; gpr_rs = 5'd3;
    #1;
    check("gpr_r7_after", gpr_rrt, 32'd42);
    gpr_model[3] = 32'h0000DEAD;
    gpr_model[7] = 32'd42;

    // Randomized GPR traffic against an array model.
    for (int i = 0; i < 150; i++) begin
      gpr_we  = 1'($urandom_range(0, 1));
      gpr_rd  = 5'($urandom_range(0, 31));
      gpr_rrd = $urandom();
      gpr_rs  = ($urandom_range(0, 3) == 0) ? gpr_rd : 5'($urandom_range(0, 31));
      gpr_rt  = 5'($urandom_range(0, 31));
      #1;
      ea = (gpr_we && gpr_rd != 5'd0 && gpr_rd == gpr_rs) ? gpr_rrd : gpr_model[gpr_rs];
      eb = (gpr_we && gpr_rd != 5'd0 && gpr_rd == gpr_rt) ? gpr_rrd : gpr_model[gpr_rt];
      check("gpr_rand_rs", gpr_rrs, ea);
      check("gpr_rand_rt", gpr_rrt, eb);
      if (gpr_we && gpr_rd != 5'd0) gpr_model[gpr_rd] = gpr_rrd;
      step();
    end
    gpr_we = 1'b0;

    // MEM directed: write, aliased overwrite, old-value-before-edge, hold.
    mem_we = 1'b1; mem_addr = 32'd4; mem_in = 32'h00001111;
    step();
    check("mem_w4", mem_out, 32'h00001111);
    mem_addr = 32'd4 + 32'(MN); mem_in = 32'h0000CAFE;
    #1;
    check("mem_old_before_edge", mem_out, 32'h00001111);
    step();
    check("mem_alias_after", mem_out, 32'h0000CAFE);
    mem_we = 1'b0; mem_addr = 32'd4; mem_in = 32'h0;
    step();
    check("mem_we0_hold", mem_out, 32'h0000CAFE);

    // Randomized MEM traffic on a private window, written before read.
    for (int i = 0; i < 16; i++) begin
      mem_we = 1'b1; mem_addr = 32'(100 + i) + 32'($urandom_range(0, 3)) * 32'(MN);
      mem_in = $urandom();
      mem_model[100 + i] = mem_in;
      step();
    end
    for (int i = 0; i < 120; i++) begin
      idx = 100 + $urandom_range(0, 15);
      mem_we = 1'($urandom_range(0, 1));
      mem_addr = 32'(idx) + 32'($urandom_range(0, 7)) * 32'(MN);
      mem_in = $urandom();
      #1;
      check("mem_rand_pre", mem_out, mem_model[idx]);
      step();
      if (mem_we) mem_model[idx] = mem_in;
      check("mem_rand_post", mem_out, mem_model[idx]);
    end
    mem_we = 1'b0;

    // Mid-run reset: ALU and GPR clear, writes during reset are dropped,
    // MEM keeps its contents.
    alu_opcode = 6'd0; alu_funct = 6'd32; alu_rrs = 32'd5; alu_rrt = 32'd7;
    alu_opcode_fwd = 6'd0; alu_funct_fwd = 6'd32;
    step();
    check("pre_reset_alu", alu_rslt, 32'd12);
    rst = 1'b1;
    gpr_we = 1'b1; gpr_rd = 5'd9; gpr_rrd = 32'd77;
    step();
    check("midreset_alu", alu_rslt, 32'd0);
    rst = 1'b0; gpr_we = 1'b0;
    alu_opcode = 6'd2; alu_funct = 6'd0;
    gpr_rs = 5'd3; gpr_rt = 5'd7; mem_addr = 32'd4;
    #1;
    check("midreset_r3", gpr_rrs, 32'd0);
    check("midreset_r7", gpr_rrt, 32'd0);
    check("midreset_mem4", mem_out, 32'h0000CAFE);
    gpr_rs = 5'd9;
    #1;
    check("midreset_r9_dropped", gpr_rrs, 32'd0);
    step();
    check("postreset_j_alu", alu_rslt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
